// File: rtl/clk_div_n.sv
// Programmable 50%-duty integer clock divider (N = 2 .. 2^WIDTH-1).
// The divisor changes only on period boundaries; odd N uses a negedge phase flop.
module clk_div_n #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] div,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [WIDTH-1:0] div_cur,
  output logic             div_err
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] half;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] last;
  logic             p_q;
  logic             n_q;
  logic             odd;
  logic             boundary;

  assign half     = div_cur >> 1;
  assign odd      = div_cur[0];
  assign cnt_inc  = cnt + WIDTH'(1);
  assign last     = div_cur - WIDTH'(1);
  assign boundary = (state == IDLE) || (cnt == last);
  assign running  = (state == RUN);
  assign clk_out  = p_q | n_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      p_q     <= 1'b0;
      tick    <= 1'b0;
      div_err <= 1'b0;
      div_cur <= DEF_DIV;
      pend    <= DEF_DIV;
    end else begin
      if (boundary) begin
        // div_cur picks up the pend value held before this edge, so a load
        // arriving in the boundary cycle itself waits for the next boundary.
        div_cur <= pend;
        cnt     <= '0;
        if (en) begin
          state <= RUN;
          p_q   <= 1'b1;
          tick  <= 1'b1;
        end else begin
          state <= IDLE;
          p_q   <= 1'b0;
          tick  <= 1'b0;
        end
      end else begin
        cnt  <= cnt_inc;
        p_q  <= (cnt_inc < half);
        tick <= 1'b0;
      end

      div_err <= 1'b0;
      if (div_load) begin
        if (div >= MIN_DIV) begin
          pend <= div;
        end else begin
          div_err <= 1'b1;
        end
      end
    end
  end

  // Extends the high phase by half a clk_in cycle for odd divisors.
  always_ff @(negedge clk_in) begin
    if (reset) begin
      n_q <= 1'b0;
    end else begin
      n_q <= p_q & odd;
    end
  end

endmodule

// File: tb/tb_clk_div_n.sv
// Bench for clk_div_n: directed vector table, directed corner sequences and
// randomized traffic checked against a period-level behavioural model.
module tb_clk_div_n;
  localparam int W   = 8;
  localparam int DEF = 3;

  logic         clk_in = 1'b0;
  logic         reset;
  logic         en;
  logic [W-1:0] div;
  logic         div_load;
  logic         clk_out;
  logic         tick;
  logic         running;
  logic [W-1:0] div_cur;
  logic         div_err;

  clk_div_n #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .en       (en),
    .div      (div),
    .div_load (div_load),
    .clk_out  (clk_out),
    .tick     (tick),
    .running  (running),
    .div_cur  (div_cur),
    .div_err  (div_err)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  // Model: whether periods run, divisor and position of the current period,
  // pending divisor, and the pulses produced at the last edge.
  bit m_run;
  int m_n;
  int m_k;
  int m_pend;
  bit m_tick;
  bit m_err;
  bit m_rst;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit e, input int d, input bit l);
    bit bnd;
    int np;
    m_rst = r;
    if (r) begin
      m_run  = 1'b0;
      m_k    = 0;
      m_n    = DEF;
      m_pend = DEF;
      m_tick = 1'b0;
      m_err  = 1'b0;
    end else begin
      bnd   = !m_run || (m_k == m_n - 1);
      np    = m_pend;
      m_err = 1'b0;
      if (l) begin
        if (d >= 2) np = d;
        else m_err = 1'b1;
      end
      if (bnd) begin
        m_n    = m_pend;
        m_k    = 0;
        m_run  = e;
        m_tick = e;
      end else begin
        m_k++;
        m_tick = 1'b0;
      end
      m_pend = np;
    end
  endtask

  // Output high for exactly N/2 clk_in cycles (in half-cycle units) from period start.
  function automatic int exp_first_half();
    return (m_run && (2 * m_k + 1 <= m_n)) ? 1 : 0;
  endfunction

  function automatic int exp_second_half();
    return (m_run && (2 * m_k + 2 <= m_n)) ? 1 : 0;
  endfunction

  task automatic edge_in(input bit r, input bit e, input int d, input bit l);
    reset    = r;
    en       = e;
    div      = W'(d);
    div_load = l;
    @(posedge clk_in);
    model_edge(r, e, d, l);
    #1;
  endtask

  task automatic half_cycle();
    @(negedge clk_in);
    #1;
  endtask

  task automatic step(input bit r, input bit e, input int d, input bit l);
    edge_in(r, e, d, l);
    chk("running", int'(running), int'(m_run));
    chk("tick", int'(tick), int'(m_tick));
    chk("div_cur", int'(div_cur), m_n);
    chk("div_err", int'(div_err), int'(m_err));
    if (!m_rst) chk("clk_out_first_half", int'(clk_out), exp_first_half());
    half_cycle();
    chk("clk_out_second_half", int'(clk_out), exp_second_half());
  endtask

  // Advance until the model sits in a boundary cycle while running.
  task automatic go_to_boundary();
    int i;
    for (i = 0; i < 300 && !(m_run && m_k == m_n - 1); i++) step(1'b0, 1'b1, 0, 1'b0);
    chk("reach_boundary", (m_run && m_k == m_n - 1) ? 1 : 0, 1);
  endtask

  typedef struct {
    bit r; bit e; int d; bit l;
    bit x_run; bit x_tick; bit x_err; int x_dc;
    bit chk_post; bit x_post; bit x_mid;
  } vec_t;

  vec_t tbl[20];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 0, 1'b0,  1'b0, 1'b0, 1'b0, 3,  1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 0, 1'b0,  1'b0, 1'b0, 1'b0, 3,  1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 0, 1'b0,  1'b0, 1'b0, 1'b0, 3,  1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 0, 1'b0,  1'b1, 1'b1, 1'b0, 3,  1'b1, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 0, 1'b0,  1'b1, 1'b0, 1'b0, 3,  1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 0, 1'b0,  1'b1, 1'b0, 1'b0, 3,  1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 0, 1'b0,  1'b1, 1'b1, 1'b0, 3,  1'b1, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 0, 1'b0,  1'b1, 1'b0, 1'b0, 3,  1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1, 1'b1,  1'b1, 1'b0, 1'b1, 3,  1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 0, 1'b0,  1'b1, 1'b1, 1'b0, 3,  1'b1, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 0, 1'b1,  1'b1, 1'b0, 1'b1, 3,  1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 0, 1'b0,  1'b1, 1'b0, 1'b0, 3,  1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 0, 1'b0,  1'b0, 1'b0, 1'b0, 3,  1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 4, 1'b1,  1'b0, 1'b0, 1'b0, 3,  1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 0, 1'b0,  1'b0, 1'b0, 1'b0, 4,  1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 0, 1'b0,  1'b1, 1'b1, 1'b0, 4,  1'b1, 1'b1, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 0, 1'b0,  1'b1, 1'b0, 1'b0, 4,  1'b1, 1'b1, 1'b1};
    tbl[17] = '{1'b0, 1'b1, 0, 1'b0,  1'b1, 1'b0, 1'b0, 4,  1'b1, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 0, 1'b0,  1'b1, 1'b0, 1'b0, 4,  1'b1, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 0, 1'b0,  1'b1, 1'b1, 1'b0, 4,  1'b1, 1'b1, 1'b1};

    // Vector table: reset, default divide by 3, invalid loads, stop, load 4 while idle.
    for (int i = 0; i < 20; i++) begin
      edge_in(tbl[i].r, tbl[i].e, tbl[i].d, tbl[i].l);
      chk($sformatf("tbl%0d_running", i), int'(running), int'(tbl[i].x_run));
      chk($sformatf("tbl%0d_tick", i), int'(tick), int'(tbl[i].x_tick));
      chk($sformatf("tbl%0d_div_err", i), int'(div_err), int'(tbl[i].x_err));
      chk($sformatf("tbl%0d_div_cur", i), int'(div_cur), tbl[i].x_dc);
      if (tbl[i].chk_post) chk($sformatf("tbl%0d_clk_first", i), int'(clk_out), int'(tbl[i].x_post));
      half_cycle();
      chk($sformatf("tbl%0d_clk_second", i), int'(clk_out), int'(tbl[i].x_mid));
    end

    // Mid-period change: running at 4 (cnt=0 now), load 7 at cnt=1.
    step(1'b0, 1'b1, 0, 1'b0);
    step(1'b0, 1'b1, 7, 1'b1);
    step(1'b0, 1'b1, 0, 1'b0);
    chk("mid_load_keeps_4", int'(div_cur), 4);
    step(1'b0, 1'b1, 0, 1'b0);
    chk("mid_load_next_7", int'(div_cur), 7);
    chk("mid_load_tick", int'(tick), 1);

    // Load in the boundary cycle itself applies one period later.
    step(1'b0, 1'b1, 4, 1'b1);
    go_to_boundary();
    step(1'b0, 1'b1, 0, 1'b0);
    chk("to_4", int'(div_cur), 4);
    go_to_boundary();
    step(1'b0, 1'b1, 7, 1'b1);
    chk("bnd_load_keeps_4", int'(div_cur), 4);
    go_to_boundary();
    step(1'b0, 1'b1, 0, 1'b0);
    chk("bnd_load_then_7", int'(div_cur), 7);

    // Two valid loads in one period: the last wins.
    step(1'b0, 1'b1, 6, 1'b1);
    step(1'b0, 1'b1, 9, 1'b1);
    go_to_boundary();
    step(1'b0, 1'b1, 0, 1'b0);
    chk("last_load_wins", int'(div_cur), 9);

    // Clean stop: N=5, drop en at cnt=2.
    step(1'b0, 1'b1, 5, 1'b1);
    go_to_boundary();
    step(1'b0, 1'b1, 0, 1'b0);
    step(1'b0, 1'b1, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);
    chk("stop_still_running", int'(running), 1);
    step(1'b0, 1'b0, 0, 1'b0);
    chk("stop_idle", int'(running), 0);
    chk("stop_clk_low", int'(clk_out), 0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 0, 1'b0);
    chk("restart_clk_high", int'(clk_out), 1);

    // Reset while clk_out is high in the odd half-phase of N=3.
    step(1'b0, 1'b1, 3, 1'b1);
    go_to_boundary();
    step(1'b0, 1'b1, 0, 1'b0);
    edge_in(1'b1, 1'b1, 9, 1'b1);
    chk("rst_running", int'(running), 0);
    chk("rst_div_cur", int'(div_cur), DEF);
    half_cycle();
    chk("rst_clk_low", int'(clk_out), 0);
    step(1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);
    chk("rst_pend_default", int'(div_cur), DEF);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
           int'($urandom_range(0, 12)), $urandom_range(0, 4) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
